// File: rtl/bist_sequencer.sv
// LFSR stimulus generator and MISR response compactor gated by an upstream run window;
// on window close it compares cycle count and signature against golden values and reports done/pass.
module bist_sequencer #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] MISR_TAPS = 8'hB8,
    parameter int unsigned      RUN_LEN   = 32,
    parameter logic [WIDTH-1:0] GOLDEN    = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl,
    input  logic             sig_ctrl,
    input  logic [WIDTH-1:0] resp_in,
    input  logic [WIDTH-1:0] byp_in,
    output logic [WIDTH-1:0] stim_out,
    output logic [WIDTH-1:0] signature,
    output logic             done,
    output logic             pass
);

    localparam int unsigned CNT_W     = 7;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // An all-zero seed locks the LFSR at zero for the whole run.
    if (SEED == '0) begin : g_bad_seed
        $error("bist_sequencer: SEED must be nonzero");
    end

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & LFSR_TAPS)};
    endfunction

    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] m,
                                                   input logic [WIDTH-1:0] r);
        return {m[WIDTH-2:0], ^(m & MISR_TAPS)} ^ r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [WIDTH-1:0] misr_q,  misr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             start;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1;
    assign start   = ctrl && !sig_ctrl;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_d  = lfsr_next(lfsr_q);
                    misr_d  = misr_next(misr_q, resp_in);
                    cnt_d   = cnt_inc;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sig_ctrl) begin
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (ctrl) begin
                    lfsr_d  = lfsr_next(lfsr_q);
                    misr_d  = misr_next(misr_q, resp_in);
                    cnt_d   = cnt_inc;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                pass_d  = (cnt_q == RUN_LEN_C) && (misr_q == GOLDEN);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // Restart steps from the reinit values at once so the first window cycle counts.
                if (start) begin
                    lfsr_d  = lfsr_next(SEED);
                    misr_d  = misr_next('0, resp_in);
                    cnt_d   = 7'd1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim_out  = sig_ctrl ? byp_in : lfsr_q;
    assign signature = misr_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: directed windows plus randomized windows/aborts/resets,
// checked against a queue-based model of the run (responses kept, LFSR/MISR folded on demand).
module tb_bist_sequencer;

    localparam logic [7:0] SEED    = 8'h01;
    localparam logic [7:0] LTAPS   = 8'hB8;
    localparam logic [7:0] MTAPS   = 8'hB8;
    localparam logic [7:0] GOLDEN  = 8'h00;
    localparam int         RUN_LEN = 32;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CHECK = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl = 1'b0;
    logic       sig_ctrl = 1'b0;
    logic [7:0] resp_in = 8'h00;
    logic [7:0] byp_in = 8'h00;
    logic [7:0] stim_out;
    logic [7:0] signature;
    logic       done;
    logic       pass;

    bist_sequencer #(
        .WIDTH    (8),
        .SEED     (SEED),
        .LFSR_TAPS(LTAPS),
        .MISR_TAPS(MTAPS),
        .RUN_LEN  (RUN_LEN),
        .GOLDEN   (GOLDEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .sig_ctrl (sig_ctrl),
        .resp_in  (resp_in),
        .byp_in   (byp_in),
        .stim_out (stim_out),
        .signature(signature),
        .done     (done),
        .pass     (pass)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: the responses absorbed by the current run, plus mode and result flags.
    int         m_mode = M_IDLE;
    logic [7:0] m_resp[$];
    logic       m_done = 1'b0;
    logic       m_pass = 1'b0;

    function automatic logic [7:0] m_lfsr();
        logic [7:0] x = SEED;
        for (int i = 0; i < m_resp.size(); i++) x = {x[6:0], ^(x & LTAPS)};
        return x;
    endfunction

    function automatic logic [7:0] m_misr();
        logic [7:0] m = 8'h00;
        foreach (m_resp[i]) m = {m[6:0], ^(m & MTAPS)} ^ m_resp[i];
        return m;
    endfunction

    function automatic int m_cnt();
        return (m_resp.size() > 127) ? 127 : m_resp.size();
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_resp.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic s, input logic [7:0] r);
        case (m_mode)
            M_IDLE: if (c && !s) begin
                m_resp.push_back(r);
                m_mode = M_RUN;
            end
            M_RUN: begin
                if (s) begin
                    m_resp.delete();
                    m_mode = M_IDLE;
                end else if (c) begin
                    m_resp.push_back(r);
                end else begin
                    m_mode = M_CHECK;
                end
            end
            M_CHECK: begin
                m_done = 1'b1;
                m_pass = (m_cnt() == RUN_LEN) && (m_misr() == GOLDEN);
                m_mode = M_DONE;
            end
            default: if (c && !s) begin
                m_resp.delete();
                m_resp.push_back(r);
                m_done = 1'b0;
                m_pass = 1'b0;
                m_mode = M_RUN;
            end
        endcase
    endtask

    task automatic check_outs(input string tag);
        logic [7:0] es;
        es = sig_ctrl ? byp_in : m_lfsr();
        chk({tag, ".stim"}, 32'(stim_out), 32'(es));
        chk({tag, ".sig"},  32'(signature), 32'(m_misr()));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".pass"}, 32'(pass), 32'(m_pass));
    endtask

    // One clock: apply inputs after the falling edge, check, then advance the model on the rising edge.
    task automatic cyc(input logic c, input logic s, input logic [7:0] r, input logic [7:0] b);
        ctrl = c; sig_ctrl = s; resp_in = r; byp_in = b;
        #1;
        check_outs("cyc");
        @(posedge clk);
        model_edge(c, s, r);
        @(negedge clk);
    endtask

    task automatic async_reset();
        ctrl = 1'b0; sig_ctrl = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outs("rst");
        chk("rst.stim_seed", 32'(stim_out), 32'(SEED));
        chk("rst.sig_zero", 32'(signature), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // resp_mode: 0 all zero, 1 a single 01 on window cycle 10, 2 random.
    task automatic run_window(input int len, input int resp_mode, input int abort_at, input int rst_at);
        logic [7:0] r;
        for (int i = 1; i <= len; i++) begin
            if (i == rst_at) begin
                async_reset();
                return;
            end
            if (i == abort_at) begin
                cyc(1'b1, 1'b1, 8'($urandom), 8'($urandom));
                return;
            end
            case (resp_mode)
                0:       r = 8'h00;
                1:       r = (i == 10) ? 8'h01 : 8'h00;
                default: r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            endcase
            cyc(1'b1, 1'b0, r, 8'($urandom));
        end
    endtask

    task automatic gap(input int n, input bit rand_sig);
        for (int i = 0; i < n; i++)
            cyc(1'b0, rand_sig ? 1'($urandom) : 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        logic [7:0] exp_seq[6];
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

        repeat (2) @(negedge clk);
        chk("reset.stim", 32'(stim_out), 32'h01);
        chk("reset.sig", 32'(signature), 32'h00);
        chk("reset.done", 32'(done), 32'h0);
        chk("reset.pass", 32'(pass), 32'h0);
        rst = 1'b0;
        model_reset();

        // First six window cycles present the known LFSR sequence, then finish a 32-cycle window.
        for (int i = 0; i < 6; i++) begin
            ctrl = 1'b1; sig_ctrl = 1'b0; resp_in = 8'h00;
            #1;
            chk("seq", 32'(stim_out), 32'(exp_seq[i]));
            chk("seq.sig", 32'(signature), 32'h00);
            cyc(1'b1, 1'b0, 8'h00, 8'h00);
        end
        run_window(26, 0, 0, 0);
        cyc(1'b0, 1'b0, 8'h00, 8'h00);
        chk("lat.done_early", 32'(done), 32'h0);
        cyc(1'b0, 1'b0, 8'h00, 8'h00);
        chk("full.done", 32'(done), 32'h1);
        chk("full.pass", 32'(pass), 32'h1);
        chk("full.sig", 32'(signature), 32'h00);
        gap(3, 1'b1);

        // Restart from DONE: done drops after the first window cycle, LFSR already stepped once.
        cyc(1'b1, 1'b0, 8'h00, 8'h00);
        chk("restart.done", 32'(done), 32'h0);
        chk("restart.stim", 32'(stim_out), 32'h02);
        run_window(31, 0, 0, 0);
        gap(3, 1'b0);
        chk("restart.pass", 32'(pass), 32'h1);

        // Single response error on window cycle 10.
        run_window(32, 1, 0, 0);
        gap(3, 1'b0);
        chk("err.done", 32'(done), 32'h1);
        chk("err.pass", 32'(pass), 32'h0);
        chk("err.sig_nz", 32'(signature != 8'h00), 32'h1);

        // Short window.
        run_window(31, 0, 0, 0);
        gap(3, 1'b0);
        chk("short.done", 32'(done), 32'h1);
        chk("short.pass", 32'(pass), 32'h0);

        // Abort through test mode on window cycle 15.
        run_window(14, 0, 0, 0);
        ctrl = 1'b1; sig_ctrl = 1'b1; byp_in = 8'h5A;
        #1;
        chk("byp.stim", 32'(stim_out), 32'h5A);
        cyc(1'b1, 1'b1, 8'h00, 8'h5A);
        ctrl = 1'b0; sig_ctrl = 1'b0;
        #1;
        chk("abort.stim", 32'(stim_out), 32'h01);
        chk("abort.sig", 32'(signature), 32'h00);
        chk("abort.done", 32'(done), 32'h0);
        gap(2, 1'b0);
        run_window(32, 0, 0, 0);
        gap(3, 1'b0);
        chk("after_abort.pass", 32'(pass), 32'h1);

        // Overlong window saturates the count.
        run_window(130, 0, 0, 0);
        gap(3, 1'b0);
        chk("long.pass", 32'(pass), 32'h0);

        // Asynchronous reset in the middle of a run with a nonzero signature.
        run_window(20, 2, 0, 0);
        run_window(5, 2, 0, 3);
        chk("midrst.done", 32'(done), 32'h0);

        for (int it = 0; it < 40; it++) begin
            int len, sel, abort_at, rst_at;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       len = 32;
            else if (sel == 5) len = 31;
            else if (sel == 6) len = 33;
            else               len = int'($urandom_range(1, 45));
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, len)) : 0;
            rst_at   = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, len)) : 0;
            run_window(len, int'($urandom_range(0, 2)), abort_at, rst_at);
            gap(int'($urandom_range(2, 6)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
